// File: rtl/bf_tape_ctrl.sv
// Tape-side controller for a Brainfuck core: owns the data pointer and the cached current cell.
// Optional feature: define BF_TAPE_WRAP_EN to wrap the pointer instead of saturating it.
module bf_tape_ctrl #(
    parameter int addrSize    = 9,
    parameter int contentSize = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    // Handshake: an op is taken on a rising edge where op_valid and op_ready are both high;
    // op and op_data are only looked at on that edge, and op_valid is ignored while op_ready is low.
    input  logic                   op_valid,
    input  logic [2:0]             op,
    input  logic [contentSize-1:0] op_data,
    output logic                   op_ready,
    output logic [addrSize-1:0]    addr_in,
    output logic [contentSize-1:0] dataIn,
    output logic                   write_rq,
    output logic [addrSize-1:0]    addr_out,
    input  logic [contentSize-1:0] dataOut,
    output logic [contentSize-1:0] cell_value,
    output logic                   cell_zero,
    output logic                   ptr_err,
    output logic [1:0]             fsm_state
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WRITE  = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_FETCH  = 2'd3;

    localparam logic [2:0] OP_PTR_INC  = 3'b000;
    localparam logic [2:0] OP_PTR_DEC  = 3'b001;
    localparam logic [2:0] OP_CELL_INC = 3'b010;
    localparam logic [2:0] OP_CELL_DEC = 3'b011;
    localparam logic [2:0] OP_CELL_SET = 3'b100;

    localparam logic [addrSize-1:0]    PTR_ONE = 1;
    localparam logic [addrSize-1:0]    PTR_MAX = '1;
    localparam logic [addrSize-1:0]    PTR_MIN = '0;
    localparam logic [contentSize-1:0] CUR_ONE = 1;

    logic [1:0]             state_q, state_d;
    logic [addrSize-1:0]    ptr_q, ptr_d;
    logic [contentSize-1:0] cur_q, cur_d;
    logic                   write_rq_q, write_rq_d;
    logic                   err_set;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cur_d      = cur_q;
        write_rq_d = 1'b0;
        err_set    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    case (op)
                        OP_PTR_INC: begin
                            state_d = ST_FETCH;
`ifdef BF_TAPE_WRAP_EN
                            ptr_d = ptr_q + PTR_ONE;
`else
                            if (ptr_q == PTR_MAX) err_set = 1'b1;
                            else                  ptr_d   = ptr_q + PTR_ONE;
`endif
                        end
                        OP_PTR_DEC: begin
                            state_d = ST_FETCH;
`ifdef BF_TAPE_WRAP_EN
                            ptr_d = ptr_q - PTR_ONE;
`else
                            if (ptr_q == PTR_MIN) err_set = 1'b1;
                            else                  ptr_d   = ptr_q - PTR_ONE;
`endif
                        end
                        OP_CELL_INC: begin
                            cur_d      = cur_q + CUR_ONE;
                            state_d    = ST_WRITE;
                            write_rq_d = 1'b1;
                        end
                        OP_CELL_DEC: begin
                            cur_d      = cur_q - CUR_ONE;
                            state_d    = ST_WRITE;
                            write_rq_d = 1'b1;
                        end
                        OP_CELL_SET: begin
                            cur_d      = op_data;
                            state_d    = ST_WRITE;
                            write_rq_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_WRITE:  state_d = ST_SETTLE;
            // The RAM only returns a write one edge after capture, so hold off the next op.
            ST_SETTLE: state_d = ST_IDLE;
            ST_FETCH: begin
                cur_d   = dataOut;
                state_d = ST_IDLE;
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            cur_q      <= '0;
            write_rq_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cur_q      <= cur_d;
            write_rq_q <= write_rq_d;
        end
    end

`ifdef BF_TAPE_WRAP_EN
    assign ptr_err = 1'b0;
    logic unused_err;
    assign unused_err = err_set;
`else
    logic ptr_err_q, ptr_err_d;

    assign ptr_err_d = ptr_err_q | err_set;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ptr_err_q <= 1'b0;
        else       ptr_err_q <= ptr_err_d;
    end

    assign ptr_err = ptr_err_q;
`endif

    assign op_ready   = (state_q == ST_IDLE);
    assign addr_in    = ptr_q;
    assign addr_out   = ptr_q;
    assign dataIn     = cur_q;
    assign write_rq   = write_rq_q;
    assign cell_value = cur_q;
    assign cell_zero  = (cur_q == '0);
    assign fsm_state  = state_q;

endmodule

// File: tb/tb_bf_tape_ctrl.sv
// Bench for bf_tape_ctrl: tape RAM model, transaction-level reference model and per-cycle compare.
// Honours BF_TAPE_WRAP_EN the same way as the design.
module tb_bf_tape_ctrl;

  localparam int AW    = 9;
  localparam int CW    = 8;
  localparam int DEPTH = 512;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          op_valid = 1'b0;
  logic [2:0]    op = 3'b111;
  logic [CW-1:0] op_data = '0;
  logic          op_ready;
  logic [AW-1:0] addr_in;
  logic [CW-1:0] dataIn;
  logic          write_rq;
  logic [AW-1:0] addr_out;
  logic [CW-1:0] dataOut;
  logic [CW-1:0] cell_value;
  logic          cell_zero;
  logic          ptr_err;
  logic [1:0]    fsm_state;

  int tests = 0;
  int fails = 0;

  bf_tape_ctrl #(.addrSize(AW), .contentSize(CW)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .op_data(op_data),
    .op_ready(op_ready), .addr_in(addr_in), .dataIn(dataIn), .write_rq(write_rq),
    .addr_out(addr_out), .dataOut(dataOut), .cell_value(cell_value),
    .cell_zero(cell_zero), .ptr_err(ptr_err), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // tape RAM: synchronous write, combinational read, cleared by the system reset
  logic [CW-1:0] tape [0:DEPTH-1];
  assign dataOut = tape[addr_out];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) tape[i] <= '0;
    end else if (write_rq) begin
      tape[addr_in] <= dataIn;
    end
  end

  // reference model
  int m_ptr, m_cur, m_prev, m_err;
  int m_tape [DEPTH];
  bit m_fetch;
  bit run_chk = 1'b0;
  logic [AW+CW-1:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void write_cell(input int v);
    m_cur = v;
    m_tape[m_ptr] = v;
    exp_q.push_back({AW'(m_ptr), CW'(v)});
  endfunction

  function automatic void model_apply(input logic [2:0] o, input logic [CW-1:0] d);
    m_fetch = 1'b0;
    case (o)
      3'b000, 3'b001: begin
        m_prev = m_cur;
        if (o == 3'b000) begin
          if (m_ptr == DEPTH - 1) begin
`ifdef BF_TAPE_WRAP_EN
            m_ptr = 0;
`else
            m_err = 1;
`endif
          end else m_ptr = m_ptr + 1;
        end else begin
          if (m_ptr == 0) begin
`ifdef BF_TAPE_WRAP_EN
            m_ptr = DEPTH - 1;
`else
            m_err = 1;
`endif
          end else m_ptr = m_ptr - 1;
        end
        m_cur   = m_tape[m_ptr];
        m_fetch = 1'b1;
      end
      3'b010:  write_cell((m_cur + 1) % 256);
      3'b011:  write_cell((m_cur + 255) % 256);
      3'b100:  write_cell(int'(d));
      default: ;
    endcase
  endfunction

  function automatic void model_reset();
    m_ptr = 0; m_cur = 0; m_prev = 0; m_err = 0; m_fetch = 1'b0;
    foreach (m_tape[i]) m_tape[i] = 0;
    exp_q.delete();
  endfunction

  // scoreboard / compare, once per cycle on the falling edge
  always @(negedge clk) begin
    if (run_chk && !reset) begin
      int vis;
      logic [AW+CW-1:0] e;
      if (write_rq) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got addr %0d data %0h expected no write (t=%0t)",
                   addr_in, dataIn, $time);
        end else begin
          e = exp_q.pop_front();
          check("write_addr_data", 32'({addr_in, dataIn}), 32'(e));
        end
      end
      vis = (m_fetch && !op_ready) ? m_prev : m_cur;
      check("addr_in", 32'(addr_in), 32'(m_ptr));
      check("addr_out", 32'(addr_out), 32'(m_ptr));
      check("ptr_err", 32'(ptr_err), 32'(m_err));
      check("cell_value", 32'(cell_value), 32'(vis));
      check("dataIn", 32'(dataIn), 32'(vis));
      check("cell_zero", 32'(cell_zero), 32'(vis == 0));
    end
  end

  // driver tasks
  task automatic apply_reset();
    run_chk  = 1'b0;
    reset    = 1'b1;
    op_valid = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset   = 1'b0;
    run_chk = 1'b1;
  endtask

  task automatic do_op(input logic [2:0] o, input logic [CW-1:0] d);
    int lat;
    int exp_lat;
    lat = 0;
    while (!op_ready && lat < 16) begin
      @(negedge clk);
      lat++;
    end
    check("ready_before_op", 32'(op_ready), 32'd1);
    op_valid = 1'b1;
    op       = o;
    op_data  = d;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op       = 3'b111;
    op_data  = '0;
    model_apply(o, d);
    exp_lat = (o <= 3'b001) ? 2 : ((o <= 3'b100) ? 3 : 1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!op_ready && lat < 16);
    check("op_latency", 32'(lat), 32'(exp_lat));
  endtask

  task automatic summary();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before %0t", $time);
    fails++;
    summary();
    $fatal(1, "watchdog");
  end

  localparam int NCHK = 4;
  logic [CW-1:0] tbl_vals [NCHK] = '{8'h11, 8'hA5, 8'h00, 8'hFE};

  initial begin
    #1;
    apply_reset();

    // reset values
    check("rst_op_ready", 32'(op_ready), 32'd1);
    check("rst_write_rq", 32'(write_rq), 32'd0);
    check("rst_addr_in", 32'(addr_in), 32'd0);
    check("rst_addr_out", 32'(addr_out), 32'd0);
    check("rst_dataIn", 32'(dataIn), 32'd0);
    check("rst_cell_value", 32'(cell_value), 32'd0);
    check("rst_cell_zero", 32'(cell_zero), 32'd1);
    check("rst_ptr_err", 32'(ptr_err), 32'd0);

    // three increments at address 0
    repeat (3) do_op(3'b010, 8'h00);
    check("inc3_value", 32'(cell_value), 32'h03);
    check("inc3_zero", 32'(cell_zero), 32'd0);
    check("inc3_tape0", 32'(tape[0]), 32'h03);

    // set / move / set / move back
    do_op(3'b100, 8'h41);
    do_op(3'b000, 8'h00);
    do_op(3'b100, 8'h07);
    do_op(3'b001, 8'h00);
    check("fetch_back_41", 32'(cell_value), 32'h41);
    do_op(3'b000, 8'h00);
    check("fetch_fwd_07", 32'(cell_value), 32'h07);

    // cell arithmetic wraps
    do_op(3'b001, 8'h00);
    check("fetch_again_41", 32'(cell_value), 32'h41);
    do_op(3'b100, 8'h00);
    do_op(3'b011, 8'h00);
    check("dec_from_0_value", 32'(cell_value), 32'hFF);
    check("dec_from_0_dataIn", 32'(dataIn), 32'hFF);
    do_op(3'b010, 8'h00);
    check("inc_from_ff_value", 32'(cell_value), 32'h00);
    check("inc_from_ff_zero", 32'(cell_zero), 32'd1);

    // pointer below zero
    do_op(3'b001, 8'h00);
`ifdef BF_TAPE_WRAP_EN
    check("ptr_dec_0_addr", 32'(addr_out), 32'd511);
    check("ptr_dec_0_err", 32'(ptr_err), 32'd0);
`else
    check("ptr_dec_0_addr", 32'(addr_out), 32'd0);
    check("ptr_dec_0_err", 32'(ptr_err), 32'd1);
`endif

    // NOPs: one-cycle turnaround, nothing moves
    do_op(3'b101, 8'hAA);
    do_op(3'b110, 8'hBB);
    do_op(3'b111, 8'hCC);
    do_op(3'b000, 8'h00);
`ifdef BF_TAPE_WRAP_EN
    check("err_after_moves", 32'(ptr_err), 32'd0);
`else
    check("err_sticky", 32'(ptr_err), 32'd1);
`endif

    // pointer past the top
    apply_reset();
    for (int i = 0; i < DEPTH; i++) do_op(3'b000, 8'h00);
`ifdef BF_TAPE_WRAP_EN
    check("ptr_top_addr", 32'(addr_in), 32'd0);
    check("ptr_top_err", 32'(ptr_err), 32'd0);
`else
    check("ptr_top_addr", 32'(addr_in), 32'd511);
    check("ptr_top_err", 32'(ptr_err), 32'd1);
`endif

    // small table across several cells, then read back
    apply_reset();
    for (int i = 0; i < NCHK; i++) begin
      do_op(3'b100, tbl_vals[i]);
      do_op(3'b000, 8'h00);
    end
    for (int i = 0; i < NCHK; i++) do_op(3'b001, 8'h00);
    check("table_cell0", 32'(cell_value), 32'h11);
    do_op(3'b000, 8'h00);
    check("table_cell1", 32'(cell_value), 32'hA5);

    // op_valid held through WRITE/SETTLE while op changes: only the first op runs
    op_valid = 1'b1;
    op       = 3'b010;
    op_data  = 8'h00;
    @(posedge clk);
    #1;
    model_apply(3'b010, 8'h00);
    @(negedge clk);
    op = 3'b000;
    @(negedge clk);
    op      = 3'b100;
    op_data = 8'h99;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op       = 3'b111;
    op_data  = '0;
    @(negedge clk);
    check("held_valid_value", 32'(cell_value), 32'hA6);
    check("held_valid_addr", 32'(addr_in), 32'd1);

    // reset lands in the middle of WRITE
    op_valid = 1'b1;
    op       = 3'b010;
    @(posedge clk);
    #2;
    check("write_rq_in_write", 32'(write_rq), 32'd1);
    run_chk  = 1'b0;
    reset    = 1'b1;
    op_valid = 1'b0;
    op       = 3'b111;
    model_reset();
    #1;
    check("abort_write_rq", 32'(write_rq), 32'd0);
    check("abort_addr", 32'(addr_in), 32'd0);
    check("abort_cell", 32'(cell_value), 32'd0);
    check("abort_ready", 32'(op_ready), 32'd1);
    repeat (2) @(negedge clk);
    reset   = 1'b0;
    run_chk = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_tape1", 32'(tape[1]), 32'd0);
    do_op(3'b010, 8'h00);
    check("after_abort_inc", 32'(cell_value), 32'h01);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    run_chk = 1'b0;
    summary();
    $finish;
  end

endmodule

// File: doc/bf_tape_ctrl.md
BF_TAPE_CTRL -- requirements
Module: bf_tape_ctrl

Interface
REQ-001 SHALL have parameter addrSize, default 9, tape address width.
REQ-002 SHALL have parameter contentSize, default 8, cell width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port op_valid  input  1  operation request.
REQ-006 SHALL have port op  input  3  000 PTR_INC, 001 PTR_DEC, 010 CELL_INC, 011 CELL_DEC, 100 CELL_SET, 101-111 NOP.
REQ-007 SHALL have port op_data  input  contentSize  value for CELL_SET.
REQ-008 SHALL have port op_ready  output  1  high only in IDLE; op accepted when op_valid and op_ready are high on the same edge.
REQ-009 SHALL have port addr_in  output  addrSize  tape write address (= ptr).
REQ-010 SHALL have port dataIn  output  contentSize  tape write data (= cur).
REQ-011 SHALL have port write_rq  output  1  tape write strobe, registered.
REQ-012 SHALL have port addr_out  output  addrSize  tape read address (= ptr).
REQ-013 SHALL have port dataOut  input  contentSize  tape read data from the tape RAM.
REQ-014 SHALL have port cell_value  output  contentSize  current cell (cur register).
REQ-015 SHALL have port cell_zero  output  1  (cur == 0), for loop decisions.
REQ-016 SHALL have port ptr_err  output  1  sticky pointer-range error.

Function
REQ-017 SHALL implement FSM states IDLE, WRITE, SETTLE, FETCH.
REQ-018 SHALL, in IDLE on accepted CELL_INC/CELL_DEC/CELL_SET, load cur with cur+1 / cur-1 / op_data at that edge and go to WRITE.
REQ-019 SHALL compute cell arithmetic modulo 2^contentSize (0xFF+1 = 0x00, 0x00-1 = 0xFF).
REQ-020 SHALL assert write_rq for exactly the one WRITE cycle, with addr_in = ptr and dataIn = cur, then go to SETTLE.
REQ-021 SHALL spend exactly one cycle in SETTLE (tape RAM makes a write readable one edge after capture), then return to IDLE; cell-op latency 3 cycles accept-to-ready.
REQ-022 SHALL, in IDLE on accepted PTR_INC/PTR_DEC, update ptr at that edge and go to FETCH.
REQ-023 SHALL, in FETCH, drive addr_out = new ptr, latch dataOut into cur at end of cycle, return to IDLE; ptr-op latency 2 cycles.
REQ-024 SHALL treat NOP as accepted with no state change, staying in IDLE (op_ready stays high).
REQ-025 SHALL keep write_rq low in all states other than WRITE.
REQ-026 SHALL ignore op_valid while op_ready is low; op and op_data only sampled on acceptance.
REQ-027 SHALL keep cell_value and cell_zero stable except at the edges defined in REQ-018 and REQ-023.

Reset
REQ-028 SHALL, on reset assertion at any time, immediately force state IDLE, ptr 0, cur 0, ptr_err 0, write_rq 0, op_ready 1 after release.
REQ-029 SHALL abort any in-flight WRITE/SETTLE/FETCH on reset with no further tape write; tape RAM is cleared by the same system reset event, so cur = 0 is consistent.
REQ-030 SHALL give outputs at reset: addr_in 0, addr_out 0, dataIn 0, cell_value 0, cell_zero 1, ptr_err 0.

Configuration
REQ-031 SHALL use macro BF_TAPE_WRAP_EN.
REQ-032 SHALL, with BF_TAPE_WRAP_EN defined, wrap ptr modulo 2^addrSize (max+1 -> 0, 0-1 -> max) and tie ptr_err to 0.
REQ-033 SHALL, without BF_TAPE_WRAP_EN, saturate ptr at 0 and 2^addrSize-1, set ptr_err sticky on any move past a bound, and still perform FETCH.

Verification
REQ-034 SHALL cover: reset, CELL_INC x3 -> write_rq pulses 3 times at addr 0, data 1,2,3; cell_value 3, cell_zero 0; each op 3 cycles.
REQ-035 SHALL cover: CELL_SET 0x41, PTR_INC, CELL_SET 0x07, PTR_DEC -> cell_value 0x41 after FETCH; PTR_INC -> 0x07.
REQ-036 SHALL cover: CELL_DEC from 0 -> cell_value 0xFF, dataIn 0xFF; CELL_INC -> 0x00, cell_zero 1.
REQ-037 SHALL cover: PTR_DEC from 0 -> with BF_TAPE_WRAP_EN ptr 511, ptr_err 0; without, ptr 0, ptr_err 1 until reset.
REQ-038 SHALL cover: op_valid held high through WRITE/SETTLE with changing op -> only the first op executes; reset asserted during WRITE -> no write_rq, ptr 0, cur 0.
